// File: rtl/AMITypes.sv
// ---------------------------------------------------------------------------
// AMITypes: shared AMI request/response/tag types and sizing constants. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package AMITypes;

  localparam int AMI_NUM_APPS     = 2;
  localparam int AMI_NUM_PORTS    = 2;
  localparam int AMI_NUM_CHANNELS = 2;
  localparam int AMI_ADDR_W       = 32;
  localparam int AMI_DATA_W       = 32;
  localparam int AMI_SIZE_W       = 4;

  localparam int AMI_APP_W  = (AMI_NUM_APPS > 1) ? $clog2(AMI_NUM_APPS) : 1;
  localparam int AMI_PORT_W = (AMI_NUM_PORTS > 1) ? $clog2(AMI_NUM_PORTS) : 1;
  localparam int AMI_CHAN_W = (AMI_NUM_CHANNELS > 1) ? $clog2(AMI_NUM_CHANNELS) : 1;

  localparam int CHAN_ARB_TAG_Q_DEPTH = 4;
  localparam int CHAN_ARB_NUM_REQ     = AMI_NUM_APPS * AMI_NUM_PORTS;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [AMI_APP_W-1:0]  srcApp;
    logic [AMI_PORT_W-1:0] srcPort;
    logic [AMI_CHAN_W-1:0] channel;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIReq;

  typedef struct packed {
    logic                  valid;
    logic [AMI_APP_W-1:0]  srcApp;
    logic [AMI_PORT_W-1:0] srcPort;
    logic [AMI_CHAN_W-1:0] channel;
    logic [AMI_DATA_W-1:0] data;
    logic [AMI_SIZE_W-1:0] size;
  } AMIResp;

  typedef struct packed {
    logic [AMI_PORT_W-1:0] srcPort;
    logic [AMI_APP_W-1:0]  srcApp;
    logic [AMI_CHAN_W-1:0] channel;
    logic [AMI_SIZE_W-1:0] size;
  } AMITag;

endpackage

`default_nettype wire

// File: rtl/ami_tag_fifo.sv
// ---------------------------------------------------------------------------
// ami_tag_fifo: synchronous FIFO of AMITag with push/pop, full/empty, head, count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ami_tag_fifo
  import AMITypes::*;
#(
  parameter int DEPTH = CHAN_ARB_TAG_Q_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  AMITag         wdata_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output AMITag         head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  AMITag         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ami_chan_arbiter.sv
// ---------------------------------------------------------------------------
// ami_chan_arbiter: round-robin per-channel request scheduler with read-tag response routing. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ami_chan_arbiter
  import AMITypes::*;
#(
  parameter int NUM_REQ     = CHAN_ARB_NUM_REQ,
  parameter int CHANNEL_ID  = 0,
  parameter int TAG_Q_DEPTH = CHAN_ARB_TAG_Q_DEPTH,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  AMIReq [NUM_REQ-1:0] req_in,
  output logic  [NUM_REQ-1:0] req_in_grant,
  output AMIReq               chan_req,
  input  logic                chan_req_grant,
  input  AMIResp              chan_resp,
  output logic                chan_resp_grant,
  output AMIResp              resp_out,
  input  logic  [NUM_REQ-1:0] resp_out_grant,
  output logic  [CNT_W-1:0]   outstanding,
  output logic                tag_err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_CW = $clog2(TAG_Q_DEPTH + 1);

  AMIReq              chan_req_q, chan_req_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               tag_err_q;
  logic [NUM_REQ-1:0] eligible;
  logic               out_free, tag_space;
  logic               tag_push, tag_full, tag_empty;
  AMITag              tag_wdata, tag_head;
  logic [TAG_CW-1:0]  tag_count;
  logic [IDX_W-1:0]   head_idx;
  logic               unused_sig;

  assign out_free  = ~chan_req_q.valid | chan_req_grant;
  assign tag_space = ~tag_full | chan_resp_grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = req_in[i].valid & (req_in[i].isWrite | tag_space);
  end

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   scan;
    int               w;
    found        = 1'b0;
    win          = '0;
    scan         = '0;
    w            = 0;
    req_in_grant = '0;
    chan_req_d   = chan_req_q;
    rr_ptr_d     = rr_ptr_q;
    tag_push     = 1'b0;
    tag_wdata    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (scan >= (IDX_W + 1)'(NUM_REQ)) scan = scan - (IDX_W + 1)'(NUM_REQ);
      if (!found && eligible[scan[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = scan[IDX_W-1:0];
      end
    end
    if (chan_req_grant) chan_req_d.valid = 1'b0;
    // Grants are suppressed while reset is held so nothing is accepted and then lost.
    if (rst_n && out_free && found) begin
      w                  = int'(win);
      req_in_grant[win]  = 1'b1;
      chan_req_d         = req_in[win];
      chan_req_d.valid   = 1'b1;
      chan_req_d.srcApp  = AMI_APP_W'(w / AMI_NUM_PORTS);
      chan_req_d.srcPort = AMI_PORT_W'(w % AMI_NUM_PORTS);
      chan_req_d.channel = AMI_CHAN_W'(CHANNEL_ID);
      rr_ptr_d           = IDX_W'((w + 1) % NUM_REQ);
      tag_push           = ~req_in[win].isWrite;
      tag_wdata.srcPort  = chan_req_d.srcPort;
      tag_wdata.srcApp   = chan_req_d.srcApp;
      tag_wdata.channel  = chan_req_d.channel;
      tag_wdata.size     = chan_req_d.size;
    end
  end

  always_comb begin
    head_idx         = IDX_W'(int'(tag_head.srcApp) * AMI_NUM_PORTS + int'(tag_head.srcPort));
    resp_out         = '0;
    resp_out.valid   = chan_resp.valid & ~tag_empty;
    resp_out.srcApp  = tag_head.srcApp;
    resp_out.srcPort = tag_head.srcPort;
    resp_out.channel = tag_head.channel;
    resp_out.data    = chan_resp.data;
    resp_out.size    = chan_resp.size;
    chan_resp_grant  = resp_out.valid & resp_out_grant[head_idx];
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({tag_push, chan_resp_grant})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_req_q    <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      chan_req_q    <= chan_req_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      tag_err_q     <= tag_err_q | (chan_resp.valid & tag_empty);
    end
  end

  ami_tag_fifo #(
    .DEPTH (TAG_Q_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag_push),
    .wdata_i (tag_wdata),
    .pop_i   (chan_resp_grant),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .head_o  (tag_head),
    .count_o (tag_count)
  );

  assign chan_req    = chan_req_q;
  assign outstanding = outstanding_q;
  assign tag_err     = tag_err_q;

  // Response routing fields come from the tag; the channel's copies and the tag size are not needed.
  assign unused_sig = ^{chan_resp.srcApp, chan_resp.srcPort, chan_resp.channel, tag_head.size, tag_count};

endmodule

`default_nettype wire

// File: tb/tb_ami_chan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ami_chan_arbiter: directed self-checking bench for ami_chan_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ami_chan_arbiter;
  import AMITypes::*;

  localparam int NREQ  = 4;
  localparam int CHID  = 1;
  localparam int DEPTH = 3;
  localparam int CW    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  AMIReq [NREQ-1:0]  req_in;
  logic  [NREQ-1:0]  req_in_grant;
  AMIReq             chan_req;
  logic              chan_req_grant;
  AMIResp            chan_resp;
  logic              chan_resp_grant;
  AMIResp            resp_out;
  logic  [NREQ-1:0]  resp_out_grant;
  logic  [CW-1:0]    outstanding;
  logic              tag_err;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ami_chan_arbiter #(
    .NUM_REQ     (NREQ),
    .CHANNEL_ID  (CHID),
    .TAG_Q_DEPTH (DEPTH),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_in          (req_in),
    .req_in_grant    (req_in_grant),
    .chan_req        (chan_req),
    .chan_req_grant  (chan_req_grant),
    .chan_resp       (chan_resp),
    .chan_resp_grant (chan_resp_grant),
    .resp_out        (resp_out),
    .resp_out_grant  (resp_out_grant),
    .outstanding     (outstanding),
    .tag_err         (tag_err)
  );

  typedef struct {
    logic [3:0]  vmask;
    logic        cg;
    logic [3:0]  exp_gnt;
    logic        exp_v;
    logic        exp_app;
    logic        exp_port;
    logic [31:0] exp_addr;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic AMIReq mkreq(input logic v, input logic w, input logic [31:0] a);
    AMIReq r;
    r         = '0;
    r.valid   = v;
    r.isWrite = w;
    r.srcApp  = '1;
    r.srcPort = '1;
    r.channel = '0;
    r.addr    = a;
    r.data    = a ^ 32'h5A5A_0000;
    r.size    = 4'h4;
    return r;
  endfunction

  task automatic set_reqs(input logic [3:0] vmask, input logic [3:0] wmask, input logic [31:0] base);
    for (int i = 0; i < NREQ; i++) req_in[i] = mkreq(vmask[i], wmask[i], base + 32'(i));
  endtask

  task automatic resp_drive(input logic v, input logic [31:0] d);
    chan_resp         = '0;
    chan_resp.valid   = v;
    chan_resp.srcApp  = '1;
    chan_resp.srcPort = '1;
    chan_resp.data    = d;
    chan_resp.size    = 4'h4;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [13];

  initial begin
    // All-write fairness/backpressure table: writes never touch the tag FIFO.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h100};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 32'h111};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 32'h122};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 32'h133};
    tbl[4]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 32'h141};
    tbl[5]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 32'h153};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h160};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h170};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 32'h192};
    tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h192};
    tbl[11] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 32'h1B3};
    tbl[12] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 32'h1C1};

    set_reqs(4'b1111, 4'b0000, 32'h0);
    chan_req_grant = 1'b1;
    resp_out_grant = 4'b1111;
    resp_drive(1'b1, 32'h0);

    // Reset state, with requests and a response pending at the inputs.
    #3;
    chk("rst_chan_req_valid", chan_req.valid, 1'b0);
    chk("rst_req_in_grant", req_in_grant, 4'b0000);
    chk("rst_resp_out_valid", resp_out.valid, 1'b0);
    chk("rst_chan_resp_grant", chan_resp_grant, 1'b0);
    chk("rst_outstanding", outstanding, 16'd0);
    chk("rst_tag_err", tag_err, 1'b0);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);
    resp_drive(1'b0, 32'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      set_reqs(tbl[r].vmask, 4'b1111, 32'h100 + 32'(r) * 32'h10);
      chan_req_grant = tbl[r].cg;
      #1;
      chk($sformatf("tbl%0d_grant", r), req_in_grant, tbl[r].exp_gnt);
      tick();
      chk($sformatf("tbl%0d_valid", r), chan_req.valid, tbl[r].exp_v);
      if (tbl[r].exp_v) begin
        chk($sformatf("tbl%0d_app", r), chan_req.srcApp, tbl[r].exp_app);
        chk($sformatf("tbl%0d_port", r), chan_req.srcPort, tbl[r].exp_port);
        chk($sformatf("tbl%0d_chan", r), chan_req.channel, CHID);
        chk($sformatf("tbl%0d_addr", r), chan_req.addr, tbl[r].exp_addr);
        chk($sformatf("tbl%0d_data", r), chan_req.data, tbl[r].exp_addr ^ 32'h5A5A_0000);
      end
    end
    chk("tbl_outstanding", outstanding, 16'd0);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);
    chan_req_grant = 1'b1;
    tick();

    // Single read from requester 2 and its response.
    @(negedge clk);
    req_in[2] = mkreq(1'b1, 1'b0, 32'h1000);
    #1;
    chk("rd_grant", req_in_grant, 4'b0100);
    chk("rd_outstanding0", outstanding, 16'd0);
    tick();
    chk("rd_valid", chan_req.valid, 1'b1);
    chk("rd_app", chan_req.srcApp, 1'b1);
    chk("rd_port", chan_req.srcPort, 1'b0);
    chk("rd_chan", chan_req.channel, CHID);
    chk("rd_addr", chan_req.addr, 32'h1000);
    chk("rd_iswrite", chan_req.isWrite, 1'b0);
    chk("rd_outstanding1", outstanding, 16'd1);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);
    resp_drive(1'b1, 32'hAB);
    resp_out_grant = 4'b0100;
    #1;
    chk("rd_resp_valid", resp_out.valid, 1'b1);
    chk("rd_resp_app", resp_out.srcApp, 1'b1);
    chk("rd_resp_port", resp_out.srcPort, 1'b0);
    chk("rd_resp_chan", resp_out.channel, CHID);
    chk("rd_resp_data", resp_out.data, 32'hAB);
    chk("rd_resp_grant", chan_resp_grant, 1'b1);
    tick();
    chk("rd_outstanding2", outstanding, 16'd0);
    @(negedge clk);
    resp_drive(1'b0, 32'h0);

    // Tag FIFO fills after three reads; a write still gets through.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_in[0] = mkreq(1'b1, 1'b0, 32'h2000 + 32'(c));
      #1;
      chk($sformatf("full_rd%0d_grant", c), req_in_grant, 4'b0001);
      tick();
    end
    chk("full_outstanding", outstanding, 16'd3);
    @(negedge clk);
    req_in[0] = mkreq(1'b1, 1'b0, 32'h2003);
    req_in[1] = mkreq(1'b1, 1'b1, 32'h2100);
    #1;
    chk("full_write_grant", req_in_grant, 4'b0010);
    tick();
    chk("full_write_addr", chan_req.addr, 32'h2100);
    @(negedge clk);
    req_in[1] = mkreq(1'b0, 1'b0, 32'h0);
    resp_drive(1'b1, 32'h11);
    resp_out_grant = 4'b0001;
    #1;
    chk("full_pop_grant", chan_resp_grant, 1'b1);
    chk("full_same_cycle_grant", req_in_grant, 4'b0001);
    chk("full_resp_app", resp_out.srcApp, 1'b0);
    tick();
    chk("full_outstanding2", outstanding, 16'd3);
    chk("full_refill_addr", chan_req.addr, 32'h2003);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);
    resp_drive(1'b0, 32'h0);

    // Channel backpressure holds the output register.
    req_in[3] = mkreq(1'b1, 1'b1, 32'h3000);
    #1;
    chk("bp_grant0", req_in_grant, 4'b1000);
    tick();
    @(negedge clk);
    chan_req_grant = 1'b0;
    req_in[3] = mkreq(1'b1, 1'b1, 32'h3004);
    req_in[2] = mkreq(1'b1, 1'b1, 32'h3008);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_grant", c), req_in_grant, 4'b0000);
      tick();
      chk($sformatf("bp%0d_addr", c), chan_req.addr, 32'h3000);
      chk($sformatf("bp%0d_valid", c), chan_req.valid, 1'b1);
      @(negedge clk);
    end
    chan_req_grant = 1'b1;
    #1;
    chk("bp_release_grant", req_in_grant, 4'b0100);
    tick();
    chk("bp_release_addr", chan_req.addr, 32'h3008);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);

    // Response backpressure: head belongs to requester 0.
    resp_drive(1'b1, 32'h22);
    resp_out_grant = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("rbp%0d_valid", c), resp_out.valid, 1'b1);
      chk($sformatf("rbp%0d_cgrant", c), chan_resp_grant, 1'b0);
      tick();
      chk($sformatf("rbp%0d_outstanding", c), outstanding, 16'd3);
      @(negedge clk);
    end
    resp_out_grant = 4'b0001;
    #1;
    chk("rbp_release_cgrant", chan_resp_grant, 1'b1);
    chk("rbp_release_data", resp_out.data, 32'h22);
    tick();
    chk("rbp_outstanding2", outstanding, 16'd2);
    @(negedge clk);
    resp_drive(1'b1, 32'h33);
    tick();
    chk("rbp_outstanding1", outstanding, 16'd1);
    @(negedge clk);
    resp_drive(1'b1, 32'h44);
    tick();
    chk("rbp_outstanding0", outstanding, 16'd0);

    // Response with no tag outstanding.
    @(negedge clk);
    resp_drive(1'b1, 32'h55);
    resp_out_grant = 4'b1111;
    #1;
    chk("err_cgrant", chan_resp_grant, 1'b0);
    chk("err_resp_valid", resp_out.valid, 1'b0);
    chk("err_flag_before", tag_err, 1'b0);
    tick();
    chk("err_flag_set", tag_err, 1'b1);
    @(negedge clk);
    resp_drive(1'b0, 32'h0);
    tick();
    tick();
    chk("err_flag_sticky", tag_err, 1'b1);
    chk("err_outstanding", outstanding, 16'd0);

    // Reset with two reads outstanding and the output register loaded.
    @(negedge clk);
    req_in[1] = mkreq(1'b1, 1'b0, 32'h4000);
    #1;
    chk("mr_grant1", req_in_grant, 4'b0010);
    tick();
    @(negedge clk);
    req_in[1] = mkreq(1'b0, 1'b0, 32'h0);
    req_in[2] = mkreq(1'b1, 1'b0, 32'h4100);
    #1;
    chk("mr_grant2", req_in_grant, 4'b0100);
    tick();
    @(negedge clk);
    set_reqs(4'b0001, 4'b0001, 32'h4200);
    chan_req_grant = 1'b0;
    tick();
    chk("mr_outstanding", outstanding, 16'd2);
    chk("mr_valid", chan_req.valid, 1'b1);
    @(negedge clk);
    resp_drive(1'b1, 32'h66);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", chan_req.valid, 1'b0);
    chk("mr_rst_grant", req_in_grant, 4'b0000);
    chk("mr_rst_outstanding", outstanding, 16'd0);
    chk("mr_rst_tag_err", tag_err, 1'b0);
    chk("mr_rst_resp_valid", resp_out.valid, 1'b0);
    chk("mr_rst_cgrant", chan_resp_grant, 1'b0);
    @(negedge clk);
    resp_drive(1'b0, 32'h0);
    set_reqs(4'b1100, 4'b0000, 32'h5000);
    chan_req_grant = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("mr_post_outstanding", outstanding, 16'd0);
    chk("mr_post_grant", req_in_grant, 4'b0100);
    tick();
    chk("mr_post_app", chan_req.srcApp, 1'b1);
    chk("mr_post_port", chan_req.srcPort, 1'b0);
    chk("mr_post_addr", chan_req.addr, 32'h5002);
    chk("mr_post_outstanding1", outstanding, 16'd1);
    @(negedge clk);
    set_reqs(4'b0000, 4'b0000, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ami_chan_arbiter.md
Name: ami_chan_arbiter

Overview:
- Per-channel request scheduler. Shares one memory channel's AMIReq interface among all app/port requesters (AMI_NUM_APPS x AMI_NUM_PORTS).
- Uses round-robin arbitration and stamps each request with srcApp, srcPort and channel.
- Records a tag for every read so that the in-order channel responses are routed back to the originating app/port.
- Sits between the address-translation/channel-steering stage and the per-channel AMI2SDRAM adapter.

Parameters:
- NUM_REQ, AMI_NUM_APPS*AMI_NUM_PORTS: number of requesters; index i = srcApp*AMI_NUM_PORTS + srcPort.
- CHANNEL_ID, 0: value stamped into the channel field; range 0..AMI_NUM_CHANNELS-1.
- TAG_Q_DEPTH, CHAN_ARB_TAG_Q_DEPTH: number of outstanding reads tracked; must be ≥1.
- CNT_W, 16: width of the outstanding-read counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_in  in  NUM_REQ x $bits(AMIReq)  per-requester request; valid field qualifies it.
- req_in_grant  out  NUM_REQ  one-hot accept of req_in[i] in this cycle.
- chan_req  out  $bits(AMIReq)  registered request to the channel.
- chan_req_grant  in  1  channel accepts chan_req this cycle.
- chan_resp  in  $bits(AMIResp)  in-order read response from the channel.
- chan_resp_grant  out  1  chan_resp consumed this cycle.
- resp_out  out  $bits(AMIResp)  response with srcApp, srcPort and channel restored from the tag.
- resp_out_grant  in  NUM_REQ  per-requester ready; only the addressed bit is honoured.
- outstanding  out  CNT_W  number of reads issued and not yet returned.
- tag_err  out  1  sticky flag: a response arrived while the tag FIFO was empty.

Behaviour:
- Reset (rst_n low, asynchronous): clears chan_req.valid, resp_out.valid, req_in_grant, chan_resp_grant, outstanding, tag_err and the tag FIFO. The RR pointer is cleared to 0. The reset takes effect mid-transaction: in-flight requests and tags are discarded and no response is forwarded afterwards.
- Output register:
  - Holds one request. It is "free" when chan_req.valid=0, or when chan_req.valid=1 and chan_req_grant=1 (same-cycle refill is allowed).
  - Held contents stay stable while valid=1 and grant=0.
- Arbitration, every cycle:
  - Eligible requesters are i with req_in[i].valid=1, and with tag FIFO not full if req_in[i].isWrite=0 (reads need a tag slot; writes never do).
  - The winner is the first eligible index at or after rr_ptr, scanning modulo NUM_REQ.
  - If the output register is free and a winner exists: req_in_grant[winner]=1 in the same cycle (combinational), and the register loads the request.
  - srcApp=winner/AMI_NUM_PORTS, srcPort=winner%AMI_NUM_PORTS and channel=CHANNEL_ID overwrite the incoming fields. addr, data, size and isWrite pass unchanged.
  - rr_ptr becomes (winner+1) mod NUM_REQ. It is unchanged when there is no grant.
- Latency: req_in accept to chan_req.valid is 1 cycle. With continuous chan_req_grant the throughput is 1 request per cycle.
- Tag FIFO:
  - Push occurs when a read is loaded into the output register, not when it is issued to the channel. Push data is {srcPort, srcApp, channel, size}.
  - Pop occurs on chan_resp_grant.
  - Simultaneous push and pop is legal, including when the FIFO is full (pop frees a slot in the same cycle).
  - Full means count == TAG_Q_DEPTH.
- Response path (combinational):
  - resp_out.valid = chan_resp.valid & tag_nonempty.
  - data and size come from chan_resp. srcApp, srcPort and channel come from the head tag.
  - chan_resp_grant = resp_out.valid & resp_out_grant[head.srcApp*AMI_NUM_PORTS + head.srcPort].
  - A blocked head stalls all responses; order is preserved.
- tag_err: set when chan_resp.valid=1 and the tag FIFO is empty. It stays set until reset. The errant response is not consumed.
- outstanding:
  - +1 on a read load into the output register, -1 on chan_resp_grant. Both in the same cycle gives no change.
  - It never exceeds TAG_Q_DEPTH. It saturates at 0 if a decrement occurs while it is 0 (unreachable when tag_err=0).
- Writes: they generate no tag and no response; the channel must not return responses for writes.

Decomposition:
- Types belong in the AMITypes package:
  - AMIReq, AMIResp and AMITag (already present).
  - CHAN_ARB_TAG_Q_DEPTH (already present).
  - Add CHAN_ARB_NUM_REQ = AMI_NUM_APPS*AMI_NUM_PORTS.
- Sub-module: ami_tag_fifo, a parameterised synchronous FIFO of AMITag with push, pop, full, empty, head and count outputs. It uses the same asynchronous active-low reset.
- The RR priority picker stays inline.

Test Plan:
- Single read: NUM_REQ=4, req_in[2] read at addr 0x1000, chan_req_grant=1 -> req_in_grant=4'b0100 in cycle 0; chan_req.valid in cycle 1 with srcApp=1, srcPort=0, channel=CHANNEL_ID. Then chan_resp data 0xAB -> resp_out srcApp=1, srcPort=0, data=0xAB; outstanding goes 0→1→0.
- Fairness: all 4 requesters hold valid reads continuously with chan_req_grant=1 -> grant order 0,1,2,3,0,1,…; no requester is granted twice within any 4 consecutive grants.
- Tag full: TAG_Q_DEPTH=3, three reads issued with no responses -> fourth read is not granted, while a pending write from another requester is granted. One response -> the read is granted on the same cycle as the pop.
- Backpressure: chan_req_grant=0 for 5 cycles -> chan_req is stable, req_in_grant=0 and no drops. Downstream resp_out_grant low for the head's requester -> chan_resp_grant=0 and later responses are held.
- Error: chan_resp.valid=1 with empty tag FIFO -> tag_err=1 next cycle and stays set; chan_resp_grant=0.
- Reset: rst_n driven low with 2 reads outstanding and chan_req.valid=1 -> all outputs 0 immediately. After release, outstanding=0 and the next grant goes to the lowest eligible index.
